// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a direct-mapped BTB (2-bit counters) read at IF,
// same-cycle mispredict redirect/flush, and saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int PC_W  = 9,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [31:0]       Imm,
  input  logic              Branch,
  input  logic              JalrSel,
  input  logic              Jump,
  input  logic [31:0]       AluResult,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic [31:0]       PC_Imm,
  output logic [31:0]       PC_Four,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispred_count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_uncond;
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [31:0]       r_target [DEPTH];
  logic [1:0]        r_ctr    [DEPTH];
  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_mispred_count;

  logic [IDX_W-1:0]  w_if_idx, w_ex_idx;
  logic [TAG_W-1:0]  w_if_tag, w_ex_tag;
  logic              w_if_hit, w_ex_hit;
  logic [31:0]       w_ex_pc32;
  logic              w_is_ctl, w_taken, w_mispredict;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[PC_W-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[PC_W-1:IDX_W+2];

  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // IF prediction; reads pre-update contents when EX writes the same index.
  assign pred_taken  = !reset && w_if_hit && (r_uncond[w_if_idx] || r_ctr[w_if_idx][1]);
  assign pred_target = pred_taken ? r_target[w_if_idx] : '0;

  assign w_ex_pc32 = 32'(ex_pc);
  assign PC_Four   = w_ex_pc32 + 32'd4;
  assign PC_Imm    = JalrSel ? AluResult : (w_ex_pc32 + Imm);

  assign w_is_ctl = Branch | Jump | JalrSel;
  assign w_taken  = (Branch & AluResult[0]) | Jump | JalrSel;

  assign w_mispredict = !reset && ex_valid && (w_is_ctl || ex_pred_taken) &&
                        ((w_taken != ex_pred_taken) || (w_taken && (ex_pred_target != PC_Imm)));

  assign redirect      = w_mispredict;
  assign flush         = w_mispredict;
  assign redirect_pc   = w_mispredict ? (w_taken ? PC_Imm : PC_Four) : '0;
  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_uncond <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (ex_valid) begin
      if (w_is_ctl) begin
        if (w_taken) begin
          r_target[w_ex_idx] <= PC_Imm;
          r_uncond[w_ex_idx] <= Jump | JalrSel;
          if (w_ex_hit) begin
            if (r_ctr[w_ex_idx] != 2'd3) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          end else begin
            r_valid[w_ex_idx] <= 1'b1;
            r_tag[w_ex_idx]   <= w_ex_tag;
            r_ctr[w_ex_idx]   <= 2'b10;
          end
        end else if (w_ex_hit && (r_ctr[w_ex_idx] != 2'd0)) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (ex_pred_taken && w_ex_hit) begin
        // Non-control instruction predicted taken: the entry aliases, drop it.
        r_valid[w_ex_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (ex_valid && w_is_ctl && !(&r_br_count))
        r_br_count <= r_br_count + CNT_W'(1);
      if (w_mispredict && !(&r_mispred_count))
        r_mispred_count <= r_mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a default instance plus a CNT_W=2
// instance sharing the same stimulus to observe counter saturation.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  if_pc;
  logic        ex_valid;
  logic [8:0]  ex_pc;
  logic [31:0] Imm;
  logic        Branch, JalrSel, Jump;
  logic [31:0] AluResult;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        pred_taken, redirect, flush;
  logic [31:0] pred_target, PC_Imm, PC_Four, redirect_pc;
  logic [15:0] br_count, mispred_count;

  logic        s_pred_taken, s_redirect, s_flush;
  logic [31:0] s_pred_target, s_PC_Imm, s_PC_Four, s_redirect_pc;
  logic [1:0]  s_br_count, s_mispred_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_W(9), .DEPTH(16), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .Imm(Imm),
    .Branch(Branch), .JalrSel(JalrSel), .Jump(Jump), .AluResult(AluResult),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .PC_Imm(PC_Imm), .PC_Four(PC_Four), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_predict_unit #(.PC_W(9), .DEPTH(16), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .Imm(Imm),
    .Branch(Branch), .JalrSel(JalrSel), .Jump(Jump), .AluResult(AluResult),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .PC_Imm(s_PC_Imm), .PC_Four(s_PC_Four), .redirect(s_redirect),
    .redirect_pc(s_redirect_pc), .flush(s_flush),
    .br_count(s_br_count), .mispred_count(s_mispred_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_pc = '0; Imm = '0; Branch = 0; JalrSel = 0; Jump = 0;
    AluResult = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic ex_set(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                        input logic br, input logic jr, input logic j,
                        input logic [31:0] alu, input logic pt, input logic [31:0] ptg);
    ex_valid = v; ex_pc = pc; Imm = imm; Branch = br; JalrSel = jr; Jump = j;
    AluResult = alu; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  initial begin
    reset = 1; if_pc = 9'h040; ex_idle();
    tick(); tick();
    check("rst_pred_taken", pred_taken, 0);
    check("rst_br_count", br_count, 0);
    check("rst_mispred_count", mispred_count, 0);

    // Cold BEQ at 0x40 taken, not predicted
    reset = 0; #1;
    check("cold_pred_taken", pred_taken, 0);
    check("cold_pred_target", pred_target, 0);
    ex_set(1, 9'h040, 32'h20, 1, 0, 0, 32'd1, 0, 32'd0); #1;
    check("beq_redirect", redirect, 1);
    check("beq_flush", flush, 1);
    check("beq_redirect_pc", redirect_pc, 32'h60);
    check("beq_pc_four", PC_Four, 32'h44);
    tick(); ex_idle(); #1;
    check("beq_br_count", br_count, 1);
    check("beq_mispred_count", mispred_count, 1);
    check("beq_pred_taken", pred_taken, 1);
    check("beq_pred_target", pred_target, 32'h60);

    // Train to ctr=3 (correct prediction), then two not-taken resolves
    ex_set(1, 9'h040, 32'h20, 1, 0, 0, 32'd1, 1, 32'h60); #1;
    check("train_no_redirect", redirect, 0);
    check("train_redirect_pc", redirect_pc, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      ex_set(1, 9'h040, 32'h20, 1, 0, 0, 32'd0, 1, 32'h60); #1;
      check("nt_redirect", redirect, 1);
      check("nt_redirect_pc", redirect_pc, 32'h44);
      tick();
    end
    ex_idle(); #1;
    check("nt_pred_taken", pred_taken, 0);
    check("nt_pred_target", pred_target, 0);
    check("nt_br_count", br_count, 4);
    check("nt_mispred_count", mispred_count, 3);
    check("sat_mis_after3", s_mispred_count, 3);

    // JALR at 0x10 with wrong predicted target
    if_pc = 9'h010;
    ex_set(1, 9'h010, 32'h5, 0, 1, 0, 32'h1A0, 1, 32'h80); #1;
    check("jalr_pc_imm", PC_Imm, 32'h1A0);
    check("jalr_redirect", redirect, 1);
    check("jalr_redirect_pc", redirect_pc, 32'h1A0);
    tick(); ex_idle(); #1;
    check("jalr_pred_taken", pred_taken, 1);
    check("jalr_pred_target", pred_target, 32'h1A0);
    // Drain the counter at 0x10 to 0; the unconditional flag keeps it predicting
    for (int k = 0; k < 2; k++) begin
      ex_set(1, 9'h010, 32'h8, 1, 0, 0, 32'd0, 1, 32'h1A0); tick();
    end
    ex_idle(); #1;
    check("uncond_pred_taken", pred_taken, 1);
    check("uncond_pred_target", pred_target, 32'h1A0);
    check("uncond_br_count", br_count, 7);
    check("uncond_mispred_count", mispred_count, 6);

    // Aliasing: 0x40 and 0x80 share index 0
    ex_set(1, 9'h040, 32'h20, 1, 0, 0, 32'd1, 0, 32'd0); tick(); ex_idle();
    if_pc = 9'h040; #1;
    check("alias_trained", pred_taken, 1);
    if_pc = 9'h080; #1;
    check("alias_other_tag", pred_taken, 0);
    ex_set(1, 9'h040, 32'h0, 0, 0, 0, 32'd1, 1, 32'h60); #1;
    check("alias_redirect", redirect, 1);
    check("alias_redirect_pc", redirect_pc, 32'h44);
    tick(); ex_idle(); if_pc = 9'h040; #1;
    check("alias_invalidated", pred_taken, 0);
    check("alias_br_count", br_count, 8);
    check("alias_mispred_count", mispred_count, 8);

    // Same-cycle allocate and fetch at 0x24
    if_pc = 9'h024;
    ex_set(1, 9'h024, 32'h100, 0, 0, 1, 32'd0, 0, 32'd0); #1;
    check("samecyc_pred_old", pred_taken, 0);
    check("samecyc_redirect_pc", redirect_pc, 32'h124);
    tick(); ex_idle(); #1;
    check("samecyc_pred_new", pred_taken, 1);
    check("samecyc_pred_target", pred_target, 32'h124);

    // Bubble: nothing resolves, arithmetic still computed
    ex_set(0, 9'h040, 32'h20, 1, 0, 0, 32'd1, 0, 32'd0); #1;
    check("bubble_redirect", redirect, 0);
    check("bubble_redirect_pc", redirect_pc, 0);
    check("bubble_pc_four", PC_Four, 32'h44);
    check("bubble_pc_imm", PC_Imm, 32'h60);
    tick();
    check("bubble_br_count", br_count, 9);
    check("bubble_mispred_count", mispred_count, 9);
    check("sat_br_hold", s_br_count, 3);

    // Wrapping 32-bit arithmetic
    ex_set(0, 9'h1FC, 32'hFFFF_FE00, 1, 0, 0, 32'd0, 0, 32'd0); #1;
    check("neg_imm_pc_imm", PC_Imm, 32'hFFFF_FFFC);
    Imm = 32'hFFFF_FFFF; #1;
    check("wrap_pc_imm", PC_Imm, 32'h0000_01FB);
    check("wrap_pc_four", PC_Four, 32'h200);

    // Reset during a taken resolve at 0x30
    if_pc = 9'h024;
    ex_set(1, 9'h030, 32'h40, 0, 0, 1, 32'd0, 0, 32'd0);
    reset = 1; #1;
    check("rst_mid_redirect", redirect, 0);
    check("rst_mid_flush", flush, 0);
    check("rst_mid_pred", pred_taken, 0);
    tick(); reset = 0; ex_idle(); #1;
    check("rst_mid_br_count", br_count, 0);
    check("rst_mid_mispred_count", mispred_count, 0);
    check("rst_mid_old_entry", pred_taken, 0);
    if_pc = 9'h030; #1;
    check("rst_mid_no_alloc", pred_taken, 0);

    // Five mispredicts: 16-bit count reaches 5, 2-bit count sticks at 3
    for (int k = 0; k < 5; k++) begin
      ex_set(1, 9'h100, 32'h10, 1, 0, 0, 32'd1, 0, 32'd0); tick();
    end
    ex_idle(); #1;
    check("five_mispred_count", mispred_count, 5);
    check("sat_mispred_count", s_mispred_count, 3);
    check("sat_br_count", s_br_count, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the EX-stage branch resolver. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, read combinationally at IF. It resolves branches and jumps at EX and drives redirect/flush on a mispredict. It also keeps saturating counts of resolved control instructions and mispredicts.

Parameters:
PC_W, 9, PC width; the PC is zero-extended to 32 bits for arithmetic.
DEPTH, 16, number of BTB entries; power of 2, at least 2. IDX_W = $clog2(DEPTH).
CNT_W, 16, width of the performance counters.
Constraint: PC_W >= IDX_W+3. TAG_W = PC_W-IDX_W-2.

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high
if_pc  in  PC_W  fetch PC
pred_taken  out  1  IF prediction: redirect fetch
pred_target  out  32  IF predicted target; 0 when pred_taken=0
ex_valid  in  1  EX stage holds a live instruction (not a bubble or flushed)
ex_pc  in  PC_W  PC of the EX instruction
Imm  in  32  sign-extended immediate
Branch  in  1  conditional branch
JalrSel  in  1  JALR
Jump  in  1  JAL
AluResult  in  32  bit0 = branch condition; for JALR, the target ((rs1+imm)&~1)
ex_pred_taken  in  1  pred_taken piped from IF with this instruction
ex_pred_target  in  32  pred_target piped from IF
PC_Imm  out  32  JalrSel ? AluResult : signed(ex_pc zero-extended) + signed(Imm)
PC_Four  out  32  ex_pc zero-extended + 4
redirect  out  1  mispredict; fetch must load redirect_pc
redirect_pc  out  32  correct next PC; 0 when redirect=0
flush  out  1  equals redirect; kills IF/ID
br_count  out  CNT_W  resolved control instructions
mispred_count  out  CNT_W  mispredicts

Behaviour:
- Entry fields: valid, tag[TAG_W], target[32], ctr[2], uncond (set for JAL/JALR).
- Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2].
- IF read (combinational):
  - hit = valid & tag match on if_pc.
  - pred_taken = hit & (uncond | ctr[1]).
  - pred_target = pred_taken ? target : 0.
- EX resolve (combinational):
  - is_ctl = Branch | Jump | JalrSel.
  - taken = (Branch & AluResult[0]) | Jump | JalrSel.
  - tgt = PC_Imm.
- Mispredict = ex_valid & (is_ctl | ex_pred_taken) & ((taken != ex_pred_taken) | (taken & ex_pred_target != tgt)).
- redirect = mispredict. redirect_pc = taken ? tgt : PC_Four. Decision is same cycle, zero latency.
- BTB update (registered, only when ex_valid):
  - Control instr, hit, taken: ctr = min(ctr+1, 3); target = tgt; uncond = Jump|JalrSel.
  - Control instr, hit, not taken: ctr = max(ctr-1, 0).
  - Control instr, miss, taken: allocate/replace entry; valid=1, tag, target=tgt, ctr=2'b10, uncond = Jump|JalrSel.
  - Control instr, miss, not taken: no write.
  - Non-control instr with ex_pred_taken=1 (alias): clear valid at ex_pc's index if its tag matches.
- Counters (registered):
  - br_count += 1 when ex_valid & is_ctl.
  - mispred_count += 1 on mispredict.
  - Both saturate at all-ones, no wrap.
- Read/write same index in one cycle: IF sees the pre-update contents; the new value is visible next cycle.
- ex_valid=0: no update, redirect=0, counters hold. PC_Imm and PC_Four are still computed.
- reset (synchronous): all valid and ctr cleared; targets cleared to 0; counters to 0. Asserted mid-operation, it takes priority over the same-cycle EX update. While reset=1, pred_taken=0, redirect=0, flush=0.
- All arithmetic is 32-bit modulo. PC_Imm addition wraps silently.

Test Plan:
- Reset, then if_pc=0x40 -> pred_taken=0, pred_target=0. EX BEQ at 0x40, Imm=0x20, AluResult=1, ex_pred_taken=0 -> redirect=1, redirect_pc=0x60, mispred_count=1, br_count=1. Next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x60.
- Same BEQ trained to ctr=3, then resolved not-taken twice with ex_pred_taken=1 -> redirect_pc=0x44 both times. Third fetch -> pred_taken=0 (ctr=1).
- JALR at 0x10, AluResult=0x1A0, ex_pred_taken=1, ex_pred_target=0x80 -> redirect=1, redirect_pc=0x1A0. Entry target updated; next fetch of 0x10 predicts 0x1A0 regardless of ctr.
- Aliasing with DEPTH=16: 0x40 trained taken, then ADD at 0x80 (same index, different tag) fetched. 0x80 misses, so pred_taken=0. Then force ex_pred_taken=1 for a non-control instr at 0x40 -> redirect_pc=0x44, and the entry is invalidated.
- Same-cycle EX allocate at 0x24 with IF read of 0x24 -> pred_taken=0 that cycle, 1 the next cycle. Assert reset in the middle of a taken resolve -> no entry written, counters=0.
- CNT_W=2: five mispredicts -> mispred_count sticks at 3. Bubble (ex_valid=0, Branch=1) -> counts unchanged, redirect=0.
